rca_acc: RTL
============

RCA_ACC -- requirements
Module: rca_acc

Interface
REQ-001 Parameter WIDTH, default 4: width of the adder sum input.
REQ-002 Parameter COUNT, default 4: samples accepted per burst; legal range 1..255.
REQ-003 Parameter ACC_W, default 8: accumulator width; SHALL satisfy ACC_W >= WIDTH+1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a burst.
REQ-007 in_valid  input  1  sum/cout from the upstream adder are valid.
REQ-008 sum  input  WIDTH  adder sum result.
REQ-009 cout  input  1  adder carry-out.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 acc  output  ACC_W  running or final accumulated value.
REQ-012 cnt  output  8  samples accepted in the current burst.
REQ-013 busy  output  1  high in the ACC and DONE states.
REQ-014 done  output  1  one-cycle pulse marking a completed burst.
REQ-015 ovf  output  1  sticky overflow flag for the current burst.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-017 Sample value SHALL be {cout,sum}, zero-extended to ACC_W bits.
REQ-018 IDLE: in_ready=0; start=1 -> ACC next cycle, with acc, cnt and ovf cleared on that same edge.
REQ-019 ACC: in_ready=1 combinationally; on in_valid&in_ready, acc<=acc+sample and cnt<=cnt+1.
REQ-020 ACC: an accept that brings cnt to COUNT SHALL transition to DONE on that edge.
REQ-021 in_valid low in ACC SHALL hold all state; there is no timeout.
REQ-022 DONE: done=1 and in_ready=0 for exactly one cycle, then IDLE unconditionally.
REQ-023 start SHALL be ignored while in ACC or DONE.
REQ-024 acc, cnt and ovf SHALL hold their final values in IDLE until the next start.
REQ-025 Each accept SHALL add exactly one sample; there is no pipelining, and acc is visible one cycle after the accepting edge.

Reset
REQ-026 rst_n low SHALL force IDLE and set acc=0, cnt=0, busy=0, done=0, ovf=0 and in_ready=0 immediately, independent of clk.
REQ-027 Reset asserted mid-burst SHALL discard the partial burst; the first cycle after release is IDLE.

Configuration
REQ-028 Macro RCA_ACC_SAT_EN defined: an add exceeding 2^ACC_W-1 SHALL clamp acc to all-ones and set ovf.
REQ-029 Macro RCA_ACC_SAT_EN undefined: an add exceeding 2^ACC_W-1 SHALL wrap acc modulo 2^ACC_W and set ovf.
REQ-030 ovf SHALL remain set until the next start or reset in both builds.

Verification
REQ-031 Basic burst (WIDTH=4, COUNT=4, ACC_W=8): after start, inputs {cout,sum} = (0,0000), (0,1000), (1,0001), (0,1111), valid every cycle -> acc=40, cnt=4, done pulses once the cycle after the 4th accept, ovf=0.
REQ-032 Backpressure gaps: the same four samples with in_valid low for 2 cycles between each -> acc=40, with no extra accepts counted.
REQ-033 Overflow (ACC_W=6): four samples of (1,1111) = 31 each -> acc=60 and ovf=1 with the macro undefined; acc=63 and ovf=1 with RCA_ACC_SAT_EN defined.
REQ-034 Reset mid-burst: rst_n pulsed low after 2 accepts -> acc=0, cnt=0, busy=0 immediately; a new burst then gives correct totals.
REQ-035 start pulsed during ACC and during DONE -> ignored; the burst completes with acc unchanged and a single done pulse.
REQ-036 COUNT=1: one sample (1,1111) -> acc=31, done asserted two cycles after start, then IDLE.

Source files
------------

// File: rtl/rca_acc.sv
// Burst accumulator for an upstream ripple-carry adder: adds COUNT samples of {cout,sum}.
// Optional macro RCA_ACC_SAT_EN selects saturating (defined) or wrapping (undefined) overflow.
module rca_acc #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic [7:0]       cnt,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] sample;
    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] add_res;
    logic [7:0]       cnt_inc;

    assign sample   = ACC_W'({cout, sum});
    assign add_full = {1'b0, acc_q} + {1'b0, sample};
    assign cnt_inc  = cnt_q + 8'd1;

    // Bit ACC_W of the widened sum is the overflow indication for this add.
`ifdef RCA_ACC_SAT_EN
    assign add_res = add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign add_res = add_full[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = add_res;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_full[ACC_W];
                    if (cnt_inc == 8'(COUNT)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready = (state_q == S_ACC);
    assign busy     = (state_q == S_ACC) || (state_q == S_DONE);
    assign done     = (state_q == S_DONE);
    assign acc      = acc_q;
    assign cnt      = cnt_q;
    assign ovf      = ovf_q;

endmodule
